// File: rtl/decrypt.sv
// -----------------------------------------------------------------------------
// decrypt -- iterative AES inverse cipher (one round per clock).
//
// The round datapath (InvShiftRows -> InvSubBytes -> AddRoundKey ->
// InvMixColumns) exists once and is reused for every round. A block takes
// nr+1 rising edges, counting the edge that samples start and the edge that
// raises done.
//
// Parameters
//   nk          key length in 32-bit words (4/6/8); documentation only
//   nr          number of rounds (10/12/14); sizes keySchedule
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       begin a block; only looked at while idle
//   cipher      ciphertext, bit 0 = MSB of byte 0; captured when start is taken
//   keySchedule expanded key, round key r at bits [128*r +: 128]; hold stable
//               while busy
//   message     recovered plaintext, registered, held until the next block
//   busy        a block is in progress
//   done        one-cycle pulse in the cycle message is updated
// -----------------------------------------------------------------------------
module decrypt #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [0:127]          cipher,
  input  logic [0:128*(nr+1)-1] keySchedule,
  output logic [0:127]          message,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} fsm_t;

  localparam logic [3:0] rnd_first = 4'(nr - 1);

  // FIPS-197 inverse S-box
  localparam logic [7:0] inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // Multiply by a 4-bit constant k (0e/0b/0d/09) as a sum of a*x^i terms.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [0:127] data;      // working block between rounds
  logic [0:127] shifted;   // after InvShiftRows
  logic [0:127] subbed;    // after InvSubBytes
  logic [0:127] round_key;
  logic [0:127] keyed;     // after AddRoundKey; also the final-round result
  logic [0:127] mixed;     // after InvMixColumns
  logic [0:127] rk [0:nr];

  // nk only records which key length the schedule was expanded from.
  if (!(nk == 4 || nk == 6 || nk == 8)) begin : g_nk_unusual
  end

  for (genvar gi = 0; gi <= nr; gi++) begin : g_rk
    assign rk[gi] = keySchedule[128*gi +: 128];
  end

  always_comb begin
    round_key = rk[0];
    for (int i = 1; i <= nr; i++) begin
      if (rnd == i[3:0]) round_key = rk[i];
    end
  end

  // Byte i sits at row i%4, column i/4. InvShiftRows rotates row r right by r,
  // so output column c takes its row-r byte from input column (c - r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_lane
    localparam int row = gi % 4;
    localparam int col = gi / 4;
    localparam int src = 4 * ((col - row + 4) % 4) + row;
    assign shifted[8*gi +: 8] = data[8*src +: 8];
    assign subbed[8*gi +: 8]  = inv_sbox[shifted[8*gi +: 8]];
  end

  assign keyed = subbed ^ round_key;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    assign b0 = keyed[32*gi      +: 8];
    assign b1 = keyed[32*gi + 8  +: 8];
    assign b2 = keyed[32*gi + 16 +: 8];
    assign b3 = keyed[32*gi + 24 +: 8];
    assign mixed[32*gi      +: 8] = gf_mul(b0, 4'he) ^ gf_mul(b1, 4'hb) ^ gf_mul(b2, 4'hd) ^ gf_mul(b3, 4'h9);
    assign mixed[32*gi + 8  +: 8] = gf_mul(b0, 4'h9) ^ gf_mul(b1, 4'he) ^ gf_mul(b2, 4'hb) ^ gf_mul(b3, 4'hd);
    assign mixed[32*gi + 16 +: 8] = gf_mul(b0, 4'hd) ^ gf_mul(b1, 4'h9) ^ gf_mul(b2, 4'he) ^ gf_mul(b3, 4'hb);
    assign mixed[32*gi + 24 +: 8] = gf_mul(b0, 4'hb) ^ gf_mul(b1, 4'hd) ^ gf_mul(b2, 4'h9) ^ gf_mul(b3, 4'he);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm     <= IDLE;
      rnd     <= 4'd0;
      data    <= '0;
      message <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            data <= cipher ^ rk[nr];
            rnd  <= rnd_first;
            busy <= 1'b1;
            fsm  <= (nr > 1) ? RUN : LAST;
          end
        end
        RUN: begin
          // Full rounds use keys nr-1 down to 1; leaving after key 1 lets the
          // decrement land rnd on 0, which selects key 0 for the final round.
          data <= mixed;
          rnd  <= rnd - 4'd1;
          if (rnd == 4'd1) fsm <= LAST;
        end
        LAST: begin
          message <= keyed;
          done    <= 1'b1;
          busy    <= 1'b0;
          fsm     <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
